// File: rtl/timer_counter.sv
// timer_counter: 8-bit up/down timer driven by prescaler divided clocks, with sticky ovf/udf flags.
// Define TIMER_COMPARE_EN to enable the sticky compare-match flag cmp.
module timer_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_div2,
   input  logic             clk_div4,
   input  logic             clk_div8,
   input  logic             clk_div16,
   input  logic [2:0]       cks,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] tdr,
   input  logic [WIDTH-1:0] tcr,
   input  logic [2:0]       flag_clr,
   output logic [WIDTH-1:0] cnt,
   output logic             ovf,
   output logic             udf,
   output logic             cmp,
   output logic             tick
);
   logic             src;
   logic             src_q;
   logic [2:0]       cks_q;
   logic [WIDTH-1:0] nxt;
   logic             wrap_up;
   logic             wrap_dn;
   always_comb begin
      src     = cks == 3'd1 ? clk_div2 :
                cks == 3'd2 ? clk_div4 :
                cks == 3'd3 ? clk_div8 :
                cks == 3'd4 ? clk_div16 : 1'b0;
      // a select change suppresses the tick so a stale src_q cannot fake an edge
      tick    = ~rst & en & (cks == cks_q) & ((cks == 3'd0) | (src & ~src_q));
      nxt     = up_dn ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
      wrap_up = tick & ~load & up_dn & (&cnt);
      wrap_dn = tick & ~load & ~up_dn & ~(|cnt);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q <= 1'b0;
         cks_q <= 3'd0;
         cnt   <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         src_q <= src;
         cks_q <= cks;
         cnt   <= load ? tdr : tick ? nxt : cnt;
         ovf   <= wrap_up | (ovf & ~flag_clr[0]);
         udf   <= wrap_dn | (udf & ~flag_clr[1]);
      end
   end
`ifdef TIMER_COMPARE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cmp <= 1'b0;
      else     cmp <= (tick & ~load & (nxt == tcr)) | (cmp & ~flag_clr[2]);
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{tcr, flag_clr[2]};
   assign cmp = 1'b0;
`endif
endmodule
